// File: rtl/cci_mpf_if_pkg.sv
// cci_mpf_if_pkg: CCI base and MPF request channel types plus conversion helpers.
package cci_mpf_if_pkg;
   localparam int CCI_ALMOST_FULL_THRESHOLD = 8;
   localparam logic [3:0] eREQ_WRLINE_I = 4'h1;
   localparam logic [3:0] eREQ_RDLINE_I = 4'h4;
   typedef logic [41:0] t_cci_clAddr;
   typedef logic [15:0] t_cci_mdata;
   typedef logic [511:0] t_cci_clData;
   typedef struct packed {
      logic [3:0]  req_type;
      t_cci_clAddr address;
      t_cci_mdata  mdata;
   } t_cci_c0_ReqMemHdr;
   typedef struct packed {
      logic [5:0]  rsvd;
      logic        sop;
      logic [1:0]  cl_len;
      logic [3:0]  req_type;
      t_cci_clAddr address;
      t_cci_mdata  mdata;
   } t_cci_c1_ReqMemHdr;
   typedef struct packed {
      logic addrIsVirtual;
   } t_cci_mpf_ReqMemHdrExt;
   typedef struct packed {
      t_cci_c0_ReqMemHdr hdr;
      logic              rdValid;
   } t_if_cci_c0_Tx;
   typedef struct packed {
      t_cci_c1_ReqMemHdr hdr;
      t_cci_clData       data;
      logic              wrValid;
      logic              intrValid;
   } t_if_cci_c1_Tx;
   typedef struct packed {
      t_cci_mpf_ReqMemHdrExt ext;
      t_cci_c0_ReqMemHdr     hdr;
      logic                  rdValid;
   } t_if_cci_mpf_c0_Tx;
   typedef struct packed {
      t_cci_mpf_ReqMemHdrExt ext;
      t_cci_c1_ReqMemHdr     hdr;
      t_cci_clData           data;
      logic                  wrValid;
      logic                  intrValid;
   } t_if_cci_mpf_c1_Tx;

   function automatic logic cci_mpf_c0TxIsValid(input t_if_cci_mpf_c0_Tx t);
      return t.rdValid;
   endfunction

   function automatic logic cci_mpf_c1TxIsValid(input t_if_cci_mpf_c1_Tx t);
      return t.wrValid | t.intrValid;
   endfunction

   function automatic t_if_cci_c0_Tx cci_mpf_cvtC0TxToBase(input t_if_cci_mpf_c0_Tx t);
      return '{hdr: t.hdr, rdValid: t.rdValid};
   endfunction

   function automatic t_if_cci_c1_Tx cci_mpf_cvtC1TxToBase(input t_if_cci_mpf_c1_Tx t);
      return '{hdr: t.hdr, data: t.data, wrValid: t.wrValid, intrValid: t.intrValid};
   endfunction

   function automatic t_cci_c1_ReqMemHdr cci_updMemReqHdrRsvd(input t_cci_c1_ReqMemHdr h);
      h.rsvd = '0;
      return h;
   endfunction

   function automatic t_if_cci_c0_Tx cci_c0TxCanonical(input t_if_cci_c0_Tx t);
      t.hdr.req_type = t.rdValid ? t.hdr.req_type : '0;
      return t;
   endfunction

   function automatic t_if_cci_c1_Tx cci_c1TxCanonical(input t_if_cci_c1_Tx t);
      t.hdr.req_type = (t.wrValid | t.intrValid) ? t.hdr.req_type : '0;
      return t;
   endfunction
endpackage

// File: rtl/cci_mpf_shim_edge_fiu_if.sv
// cci_mpf_shim_edge_fiu_if: upstream MPF channels, downstream FIU channels and error flags.
interface cci_mpf_shim_edge_fiu_if;
   import cci_mpf_if_pkg::*;
   t_if_cci_mpf_c0_Tx afu_c0Tx;
   t_if_cci_mpf_c1_Tx afu_c1Tx;
   logic              afu_c0TxAlmFull;
   logic              afu_c1TxAlmFull;
   t_if_cci_c0_Tx     fiu_c0Tx;
   t_if_cci_c1_Tx     fiu_c1Tx;
   logic              fiu_c0TxAlmFull;
   logic              fiu_c1TxAlmFull;
   logic              err_virtAddr;
   logic              err_overflow;
   modport master (
      output afu_c0Tx, afu_c1Tx, fiu_c0TxAlmFull, fiu_c1TxAlmFull,
      input  afu_c0TxAlmFull, afu_c1TxAlmFull, fiu_c0Tx, fiu_c1Tx, err_virtAddr, err_overflow
   );
   modport slave (
      input  afu_c0Tx, afu_c1Tx, fiu_c0TxAlmFull, fiu_c1TxAlmFull,
      output afu_c0TxAlmFull, afu_c1TxAlmFull, fiu_c0Tx, fiu_c1Tx, err_virtAddr, err_overflow
   );
endinterface

// File: rtl/cci_mpf_prim_fifo_lutram.sv
// cci_mpf_prim_fifo_lutram: LUTRAM FIFO with occupancy-based almost-full.
module cci_mpf_prim_fifo_lutram
   import cci_mpf_if_pkg::*;
#(
   parameter int N_DATA_BITS = 64,
   parameter int N_ENTRIES   = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [N_DATA_BITS-1:0] i_enq_data,
   input  logic                   i_enq_en,
   output logic                   o_notFull,
   output logic                   o_almostFull,
   output logic [N_DATA_BITS-1:0] o_first,
   input  logic                   i_deq_en,
   output logic                   o_notEmpty
);
   localparam int AW = $clog2(N_ENTRIES);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH  = CW'(N_ENTRIES);
   localparam logic [CW-1:0] THRESH = CW'(CCI_ALMOST_FULL_THRESHOLD);

   logic [N_DATA_BITS-1:0] r_mem [N_ENTRIES];
   logic [AW-1:0]          r_wr;
   logic [AW-1:0]          r_rd;
   logic [CW-1:0]          r_cnt;
   logic [CW-1:0]          w_free;

   assign w_free       = DEPTH - r_cnt;
   assign o_notFull    = r_cnt != DEPTH;
   assign o_notEmpty   = r_cnt != '0;
   assign o_almostFull = w_free <= THRESH;
   assign o_first      = r_mem[r_rd];

   // Storage is not reset; emptiness is tracked only by the pointers and count.
   always_ff @(posedge clk) begin
      if (i_enq_en) r_mem[r_wr] <= i_enq_data;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr  <= '0;
         r_rd  <= '0;
         r_cnt <= '0;
      end else begin
         r_wr  <= r_wr + AW'(i_enq_en);
         r_rd  <= r_rd + AW'(i_deq_en);
         r_cnt <= r_cnt + CW'(i_enq_en) - CW'(i_deq_en);
      end
   end
endmodule

// File: rtl/cci_mpf_shim_edge_fiu.sv
// cci_mpf_shim_edge_fiu: buffers MPF requests per channel and emits base CCI requests to the FIU.
module cci_mpf_shim_edge_fiu
   import cci_mpf_if_pkg::*;
#(
   parameter int N_ENTRIES = 16
) (
   input logic                     clk,
   input logic                     reset,
   cci_mpf_shim_edge_fiu_if.slave  bus
);
   logic          w_c0_valid, w_c0_virt, w_c0_enq, w_c0_deq, w_c0_not_full, w_c0_not_empty, w_c0_alm;
   logic          w_c1_valid, w_c1_virt, w_c1_enq, w_c1_deq, w_c1_not_full, w_c1_not_empty, w_c1_alm;
   logic          w_virt, w_ovf;
   t_if_cci_c0_Tx w_c0_first, w_c0_out;
   t_if_cci_c1_Tx w_c1_first, w_c1_out;
   t_if_cci_c0_Tx r_fiu_c0Tx;
   t_if_cci_c1_Tx r_fiu_c1Tx;
   logic          r_err_virt, r_err_ovf;

   assign w_c0_valid = cci_mpf_c0TxIsValid(bus.afu_c0Tx);
   assign w_c1_valid = cci_mpf_c1TxIsValid(bus.afu_c1Tx);
   assign w_c0_virt  = w_c0_valid && bus.afu_c0Tx.ext.addrIsVirtual;
   assign w_c1_virt  = w_c1_valid && bus.afu_c1Tx.ext.addrIsVirtual;
   assign w_c0_enq   = w_c0_valid && !w_c0_virt && w_c0_not_full;
   assign w_c1_enq   = w_c1_valid && !w_c1_virt && w_c1_not_full;
   assign w_c0_deq   = w_c0_not_empty && !bus.fiu_c0TxAlmFull;
   assign w_c1_deq   = w_c1_not_empty && !bus.fiu_c1TxAlmFull;
   assign w_virt     = w_c0_virt | w_c1_virt;
   // Fullness is judged on the pre-edge count, so a same-edge dequeue never makes room.
   assign w_ovf      = (w_c0_valid && !w_c0_virt && !w_c0_not_full) |
                       (w_c1_valid && !w_c1_virt && !w_c1_not_full);

   assign bus.afu_c0TxAlmFull = reset | w_c0_alm;
   assign bus.afu_c1TxAlmFull = reset | w_c1_alm;
   assign bus.fiu_c0Tx        = r_fiu_c0Tx;
   assign bus.fiu_c1Tx        = r_fiu_c1Tx;
   assign bus.err_virtAddr    = r_err_virt;
   assign bus.err_overflow    = r_err_ovf;

   cci_mpf_prim_fifo_lutram #(
      .N_DATA_BITS($bits(t_if_cci_c0_Tx)),
      .N_ENTRIES  (N_ENTRIES)
   ) u_fifo_c0 (
      .clk         (clk),
      .reset       (reset),
      .i_enq_data  (cci_mpf_cvtC0TxToBase(bus.afu_c0Tx)),
      .i_enq_en    (w_c0_enq),
      .o_notFull   (w_c0_not_full),
      .o_almostFull(w_c0_alm),
      .o_first     (w_c0_first),
      .i_deq_en    (w_c0_deq),
      .o_notEmpty  (w_c0_not_empty)
   );

   cci_mpf_prim_fifo_lutram #(
      .N_DATA_BITS($bits(t_if_cci_c1_Tx)),
      .N_ENTRIES  (N_ENTRIES)
   ) u_fifo_c1 (
      .clk         (clk),
      .reset       (reset),
      .i_enq_data  (cci_mpf_cvtC1TxToBase(bus.afu_c1Tx)),
      .i_enq_en    (w_c1_enq),
      .o_notFull   (w_c1_not_full),
      .o_almostFull(w_c1_alm),
      .o_first     (w_c1_first),
      .i_deq_en    (w_c1_deq),
      .o_notEmpty  (w_c1_not_empty)
   );

   always_comb begin
      w_c0_out     = cci_c0TxCanonical(w_c0_first);
      w_c1_out     = w_c1_first;
      w_c1_out.hdr = cci_updMemReqHdrRsvd(w_c1_first.hdr);
      w_c1_out     = cci_c1TxCanonical(w_c1_out);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_fiu_c0Tx <= '0;
         r_fiu_c1Tx <= '0;
         r_err_virt <= 1'b0;
         r_err_ovf  <= 1'b0;
      end else begin
         r_fiu_c0Tx <= w_c0_deq ? w_c0_out : '0;
         r_fiu_c1Tx <= w_c1_deq ? w_c1_out : '0;
         r_err_virt <= r_err_virt | w_virt;
         r_err_ovf  <= r_err_ovf | w_ovf;
      end
   end
endmodule

// File: tb/tb_cci_mpf_shim_edge_fiu.sv
// tb_cci_mpf_shim_edge_fiu: directed bench for the FIU edge shim.
module tb_cci_mpf_shim_edge_fiu;
   import cci_mpf_if_pkg::*;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;
   int   n_emit;

   always #5 clk = ~clk;

   cci_mpf_shim_edge_fiu_if bus();

   cci_mpf_shim_edge_fiu #(.N_ENTRIES(16)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic t_if_cci_mpf_c0_Tx rd(input logic [15:0] md);
      t_if_cci_mpf_c0_Tx r;
      r             = '0;
      r.hdr.req_type = eREQ_RDLINE_I;
      r.hdr.address  = 42'h100 + 42'(md);
      r.hdr.mdata    = md;
      r.rdValid      = 1'b1;
      return r;
   endfunction

   function automatic t_if_cci_mpf_c1_Tx wr(input logic [15:0] md, input logic virt);
      t_if_cci_mpf_c1_Tx r;
      logic [63:0] w;
      w                     = 64'hA5A5_0000_0000_0000 | 64'(md);
      r                     = '0;
      r.ext.addrIsVirtual   = virt;
      r.hdr.rsvd            = 6'h3F;
      r.hdr.sop             = 1'b1;
      r.hdr.req_type        = eREQ_WRLINE_I;
      r.hdr.address         = 42'h2000 + 42'(md);
      r.hdr.mdata           = md;
      r.data                = {8{w}};
      r.wrValid             = 1'b1;
      return r;
   endfunction

   initial begin
      bus.afu_c0Tx        = '0;
      bus.afu_c1Tx        = '0;
      bus.fiu_c0TxAlmFull = 1'b0;
      bus.fiu_c1TxAlmFull = 1'b0;
      tick;
      tick;
      chk("rst_c0_almfull", bus.afu_c0TxAlmFull, 1);
      chk("rst_c1_almfull", bus.afu_c1TxAlmFull, 1);
      chk("rst_c0_valid", bus.fiu_c0Tx.rdValid, 0);
      chk("rst_c1_valid", bus.fiu_c1Tx.wrValid, 0);
      chk("rst_err_virt", bus.err_virtAddr, 0);
      chk("rst_err_ovf", bus.err_overflow, 0);
      reset = 1'b0;

      bus.afu_c0Tx = rd(16'h2A);
      tick;
      bus.afu_c0Tx = '0;
      chk("idle_almfull", bus.afu_c0TxAlmFull, 0);
      chk("basic_not_early", bus.fiu_c0Tx.rdValid, 0);
      tick;
      chk("basic_valid", bus.fiu_c0Tx.rdValid, 1);
      chk("basic_mdata", bus.fiu_c0Tx.hdr.mdata, 16'h2A);
      chk("basic_addr", bus.fiu_c0Tx.hdr.address, 42'h12A);
      chk("basic_type", bus.fiu_c0Tx.hdr.req_type, eREQ_RDLINE_I);
      tick;
      chk("basic_one_cycle", bus.fiu_c0Tx.rdValid, 0);
      chk("basic_canon_type", bus.fiu_c0Tx.hdr.req_type, 0);

      bus.afu_c1Tx = wr(16'h55, 1'b1);
      tick;
      bus.afu_c1Tx = '0;
      chk("virt_err", bus.err_virtAddr, 1);
      tick;
      chk("virt_dropped", bus.fiu_c1Tx.wrValid, 0);
      tick;
      chk("virt_dropped2", bus.fiu_c1Tx.wrValid, 0);
      chk("virt_sticky", bus.err_virtAddr, 1);

      bus.afu_c1Tx = wr(16'h66, 1'b0);
      tick;
      bus.afu_c1Tx = '0;
      tick;
      chk("wr_valid", bus.fiu_c1Tx.wrValid, 1);
      chk("wr_intr", bus.fiu_c1Tx.intrValid, 0);
      chk("wr_mdata", bus.fiu_c1Tx.hdr.mdata, 16'h66);
      chk("wr_rsvd", bus.fiu_c1Tx.hdr.rsvd, 0);
      chk("wr_sop", bus.fiu_c1Tx.hdr.sop, 1);
      chk("wr_data_lo", bus.fiu_c1Tx.data[63:0], 64'hA5A5_0000_0000_0066);
      chk("wr_data_hi", bus.fiu_c1Tx.data[511:448], 64'hA5A5_0000_0000_0066);
      tick;
      chk("wr_one_cycle", bus.fiu_c1Tx.wrValid, 0);

      bus.fiu_c0TxAlmFull = 1'b1;
      for (int i = 0; i < 17; i++) begin
         bus.afu_c0Tx = rd(16'(i));
         tick;
         if (i == 6) chk("almfull_after7", bus.afu_c0TxAlmFull, 0);
         if (i == 7) chk("almfull_after8", bus.afu_c0TxAlmFull, 1);
         if (i == 15) chk("no_ovf_at16", bus.err_overflow, 0);
      end
      bus.afu_c0Tx = '0;
      chk("ovf_at17", bus.err_overflow, 1);
      chk("held_no_out", bus.fiu_c0Tx.rdValid, 0);
      bus.fiu_c0TxAlmFull = 1'b0;
      for (int i = 0; i < 16; i++) begin
         tick;
         chk("drain_valid", bus.fiu_c0Tx.rdValid, 1);
         chk("drain_order", bus.fiu_c0Tx.hdr.mdata, 64'(i));
      end
      tick;
      chk("drain_exact16", bus.fiu_c0Tx.rdValid, 0);
      chk("drain_almfull", bus.afu_c0TxAlmFull, 0);

      bus.fiu_c1TxAlmFull = 1'b1;
      bus.afu_c1Tx = wr(16'h77, 1'b0);
      for (int i = 0; i < 10; i++) begin
         bus.afu_c0Tx = rd(16'h100 + 16'(i));
         tick;
         bus.afu_c1Tx = '0;
         if (i > 0) begin
            chk("indep_valid", bus.fiu_c0Tx.rdValid, 1);
            chk("indep_mdata", bus.fiu_c0Tx.hdr.mdata, 64'(16'h100 + 16'(i - 1)));
         end
      end
      bus.afu_c0Tx = '0;
      tick;
      chk("indep_last_valid", bus.fiu_c0Tx.rdValid, 1);
      chk("indep_last_mdata", bus.fiu_c0Tx.hdr.mdata, 16'h109);
      chk("indep_c1_held", bus.fiu_c1Tx.wrValid, 0);
      tick;
      chk("indep_c0_done", bus.fiu_c0Tx.rdValid, 0);
      bus.fiu_c1TxAlmFull = 1'b0;
      tick;
      chk("indep_c1_valid", bus.fiu_c1Tx.wrValid, 1);
      chk("indep_c1_mdata", bus.fiu_c1Tx.hdr.mdata, 16'h77);
      tick;
      chk("indep_c1_once", bus.fiu_c1Tx.wrValid, 0);

      bus.fiu_c1TxAlmFull = 1'b1;
      for (int i = 0; i < 5; i++) begin
         bus.afu_c1Tx = wr(16'h200 + 16'(i), 1'b0);
         tick;
      end
      bus.afu_c1Tx = '0;
      bus.fiu_c1TxAlmFull = 1'b0;
      tick;
      chk("mid_pre_valid", bus.fiu_c1Tx.wrValid, 1);
      chk("mid_pre_mdata", bus.fiu_c1Tx.hdr.mdata, 16'h200);
      #2;
      reset = 1'b1;
      #1;
      chk("mid_async_clear", bus.fiu_c1Tx.wrValid, 0);
      chk("mid_almfull", bus.afu_c1TxAlmFull, 1);
      chk("mid_err_virt", bus.err_virtAddr, 0);
      chk("mid_err_ovf", bus.err_overflow, 0);
      tick;
      tick;
      reset = 1'b0;
      n_emit = 0;
      for (int i = 0; i < 8; i++) begin
         tick;
         n_emit += int'(bus.fiu_c1Tx.wrValid);
      end
      chk("mid_no_emit", 64'(n_emit), 0);

      bus.afu_c0Tx = rd(16'h3C);
      tick;
      bus.afu_c0Tx = '0;
      tick;
      chk("post_rst_valid", bus.fiu_c0Tx.rdValid, 1);
      chk("post_rst_mdata", bus.fiu_c0Tx.hdr.mdata, 16'h3C);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
